// File: rtl/add_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add_share_arbiter (with helper carry_select_adder)
// Description : Round-robin arbiter that shares one N-bit carry-select adder
//               among R requesters. Each requester uses a valid/ready
//               handshake. The granted requester's operands pass through the
//               adder in the same cycle. The result is captured into a
//               one-deep output register that holds the requester ID and has
//               its own valid/ready backpressure.
//
// Ports (add_share_arbiter):
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous reset, active low
//   req_valid  in   R    per-requester operand valid
//   req_ready  out  R    per-requester accept (at most one bit set)
//   req_a      in   R*N  operand A, requester i at [i*N +: N]
//   req_b      in   R*N  operand B, same packing
//   req_cin    in   R    per-requester carry-in
//   rsp_valid  out  1    result register holds a result
//   rsp_ready  in   1    consumer accepts the result
//   rsp_id     out  IDW  index of the requester that produced the result
//   rsp_sum    out  N    registered sum
//   rsp_cout   out  1    registered carry-out
//   rsp_of     out  1    registered signed overflow
//
// Build option : ADD_ARB_PRIO0_EN
//   When defined, requester 0 has absolute priority. The pointer does not
//   move on a requester-0 transfer, and requesters 1..R-1 rotate among
//   themselves.
//
// Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// carry_select_adder: N-bit adder built from 8-bit blocks. Each block
// precomputes its sum for carry-in 0 and carry-in 1. The incoming block
// carry then selects one of them. N must be a multiple of 8.
// ----------------------------------------------------------------------------
module carry_select_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         of
);
    localparam int c_BLK_W = 8;
    localparam int c_NBLK  = N / c_BLK_W;

    logic [c_NBLK:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar gi = 0; gi < c_NBLK; gi++) begin : g_blk
        logic [c_BLK_W:0] w_s0;
        logic [c_BLK_W:0] w_s1;

        assign w_s0 = {1'b0, a[gi*c_BLK_W +: c_BLK_W]} + {1'b0, b[gi*c_BLK_W +: c_BLK_W]};
        assign w_s1 = {1'b0, a[gi*c_BLK_W +: c_BLK_W]} + {1'b0, b[gi*c_BLK_W +: c_BLK_W]}
                      + (c_BLK_W+1)'(1);

        assign sum[gi*c_BLK_W +: c_BLK_W] = w_carry[gi] ? w_s1[c_BLK_W-1:0] : w_s0[c_BLK_W-1:0];
        assign w_carry[gi+1]              = w_carry[gi] ? w_s1[c_BLK_W]     : w_s0[c_BLK_W];
    end

    assign cout = w_carry[c_NBLK];
    // Signed overflow: the operands have the same sign and the sum has the other sign.
    assign of   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
endmodule

module add_share_arbiter #(
    parameter  int N   = 32,
    parameter  int R   = 4,
    localparam int IDW = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    input  logic [R-1:0]   req_cin,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [N-1:0]   rsp_sum,
    output logic           rsp_cout,
    output logic           rsp_of
);
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_nxt;
    logic [IDW-1:0] w_gnt;
    logic           w_any;
    logic           w_can_accept;
    logic           w_xfer;

    logic [N-1:0]   w_a;
    logic [N-1:0]   w_b;
    logic           w_cin;
    logic [N-1:0]   w_sum;
    logic           w_cout;
    logic           w_of;

    logic [IDW-1:0] r_id;
    logic [N-1:0]   r_sum;
    logic           r_cout;
    logic           r_of;

    assign rsp_valid    = (r_state == S_FULL);
    // The output register can take a new result when it is empty or being drained now.
    assign w_can_accept = !rsp_valid || rsp_ready;

    // Grant search: the first valid requester at or after r_ptr, wrapping modulo R.
    always_comb begin : p_arb
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_gnt = '0;
`ifdef ADD_ARB_PRIO0_EN
        if (req_valid[0]) begin
            w_any = 1'b1;
        end
        for (int k = 0; k < R; k++) begin
            idx = (int'(r_ptr) + k) % R;
            if (!w_any && (idx != 0) && req_valid[idx]) begin
                w_any = 1'b1;
                w_gnt = IDW'(idx);
            end
        end
`else
        for (int k = 0; k < R; k++) begin
            idx = (int'(r_ptr) + k) % R;
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_gnt = IDW'(idx);
            end
        end
`endif
    end

    always_comb begin
        req_ready = '0;
        if (w_any && w_can_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    assign w_xfer = w_any && w_can_accept;

    // Operand mux into the shared adder. It depends only on the grant, so the
    // handshake never waits on operand data.
    assign w_a   = req_a[int'(w_gnt)*N +: N];
    assign w_b   = req_b[int'(w_gnt)*N +: N];
    assign w_cin = req_cin[w_gnt];

    carry_select_adder #(.N(N)) u_adder (
        .a    (w_a),
        .b    (w_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout),
        .of   (w_of)
    );

    // The pointer advances past the grantee only on a transfer.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_xfer) begin
`ifdef ADD_ARB_PRIO0_EN
            // Requester 0 is outside the rotation, so index 0 is skipped on wrap.
            if (w_gnt != '0) begin
                if (int'(w_gnt) == R-1) begin
                    w_ptr_nxt = IDW'(1);
                end else begin
                    w_ptr_nxt = w_gnt + 1'b1;
                end
            end
`else
            if (int'(w_gnt) == R-1) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = w_gnt + 1'b1;
            end
`endif
        end
    end

    // Output stage. A consume and a new transfer in the same cycle stay FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_xfer)                w_state_nxt = S_FULL;
            S_FULL:  if (rsp_ready && !w_xfer)  w_state_nxt = S_EMPTY;
            default:                            w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_xfer) begin
                r_id   <= w_gnt;
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_of   <= w_of;
            end
        end
    end

    assign rsp_id   = r_id;
    assign rsp_sum  = r_sum;
    assign rsp_cout = r_cout;
    assign rsp_of   = r_of;
endmodule
`default_nettype wire

// File: tb/tb_add_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_share_arbiter
// Description : Self-checking bench for add_share_arbiter (N=32, R=4). It
//               applies a directed vector table, hand sequences for
//               reset/round-robin/backpressure, and randomized traffic that
//               is checked every cycle against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_add_share_arbiter;
    localparam int N   = 32;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [N-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_of;

    always #5 clk = ~clk;

    add_share_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_of    (rsp_of)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic         m_valid;
    int           m_id;
    logic [N-1:0] m_sum;
    logic         m_cout;
    logic         m_of;
    int           m_ptr;
    logic         last_xfer;
    int           last_g;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant from the rules: the first valid requester searching upward from ptr with wrap.
    function automatic int model_grant();
`ifdef ADD_ARB_PRIO0_EN
        if (req_valid[0]) return 0;
        for (int k = 0; k < R; k++) begin
            int i;
            i = (m_ptr + k) % R;
            if (i != 0 && req_valid[i]) return i;
        end
`else
        for (int k = 0; k < R; k++) begin
            int i;
            i = (m_ptr + k) % R;
            if (req_valid[i]) return i;
        end
`endif
        return -1;
    endfunction

    // One clock: check req_ready, advance the model across the edge, check outputs.
    task automatic step();
        int             g;
        logic [R-1:0]   exp_rdy;
        logic           xfer;
        logic [N-1:0]   a, b;
        logic [N:0]     full;
        logic           n_valid, n_cout, n_of;
        logic [N-1:0]   n_sum;
        int             n_id, n_ptr;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0 && (!m_valid || rsp_ready)) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        xfer = (exp_rdy != '0);

        n_valid = m_valid; n_id = m_id; n_sum = m_sum; n_cout = m_cout; n_of = m_of; n_ptr = m_ptr;
        if (!rst_n) begin
            n_valid = 1'b0; n_id = 0; n_sum = '0; n_cout = 1'b0; n_of = 1'b0; n_ptr = 0;
        end else if (xfer) begin
            a       = req_a[g*N +: N];
            b       = req_b[g*N +: N];
            full    = {1'b0, a} + {1'b0, b} + (N+1)'(req_cin[g]);
            n_sum   = full[N-1:0];
            n_cout  = full[N];
            n_of    = (a[N-1] == b[N-1]) && (n_sum[N-1] != a[N-1]);
            n_id    = g;
            n_valid = 1'b1;
`ifdef ADD_ARB_PRIO0_EN
            if (g != 0) n_ptr = ((g + 1) % R == 0) ? 1 : (g + 1) % R;
`else
            n_ptr = (g + 1) % R;
`endif
        end else if (m_valid && rsp_ready) begin
            n_valid = 1'b0;
        end

        @(posedge clk);
        #1;
        m_valid = n_valid; m_id = n_id; m_sum = n_sum; m_cout = n_cout; m_of = n_of; m_ptr = n_ptr;
        last_xfer = xfer && rst_n;
        last_g    = g;

        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_id",    64'(rsp_id),    64'(m_id));
        check("rsp_sum",   64'(rsp_sum),   64'(m_sum));
        check("rsp_cout",  64'(rsp_cout),  64'(m_cout));
        check("rsp_of",    64'(rsp_of),    64'(m_of));
    endtask

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Requesters hold valid and operands until accepted, then may change.
    task automatic drive_random();
        for (int i = 0; i < R; i++) begin
            if (!(req_valid[i] && !(last_xfer && last_g == i))) begin
                req_valid[i]      = ($urandom_range(0, 99) < 55);
                req_a[i*N +: N]   = rand_op();
                req_b[i*N +: N]   = rand_op();
                req_cin[i]        = 1'($urandom_range(0, 1));
            end
        end
        rsp_ready = ($urandom_range(0, 99) < 70);
        rst_n     = ($urandom_range(0, 299) != 0);
    endtask

    typedef struct {
        int           rq;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
        logic         of;
    } vec_t;

    vec_t vecs[8];
    logic [N-1:0] saved_sum;

    initial begin
        vecs[0] = '{2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[1] = '{3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3] = '{1, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0, 1'b0};
        vecs[4] = '{0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[5] = '{1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[6] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{3, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
        m_valid = 1'b0; m_id = 0; m_sum = '0; m_cout = 1'b0; m_of = 1'b0; m_ptr = 0;
        last_xfer = 1'b0; last_g = -1;
        @(posedge clk);
        #1;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step();
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_sum",   64'(rsp_sum),   64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);

        // Idle after release
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("idle_valid", 64'(rsp_valid), 64'd0);

        // Directed vector table, one requester at a time
        rsp_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            req_valid                 = '0;
            req_valid[vecs[v].rq]     = 1'b1;
            req_a[vecs[v].rq*N +: N]  = vecs[v].a;
            req_b[vecs[v].rq*N +: N]  = vecs[v].b;
            req_cin[vecs[v].rq]       = vecs[v].cin;
            step();
            check("vec_id",   64'(rsp_id),   64'(vecs[v].rq));
            check("vec_sum",  64'(rsp_sum),  64'(vecs[v].sum));
            check("vec_cout", 64'(rsp_cout), 64'(vecs[v].cout));
            check("vec_of",   64'(rsp_of),   64'(vecs[v].of));
        end
        req_valid = '0;
        step();

        // Restart from a known pointer
        rst_n = 1'b0; step(); rst_n = 1'b1;

        for (int i = 0; i < R; i++) begin
            req_a[i*N +: N] = 32'h0000_1000 * (i + 1);
            req_b[i*N +: N] = 32'h0000_0011;
            req_cin[i]      = 1'b0;
        end
        req_a[3*N +: N] = 32'hFFFF_FFFF;
        req_b[3*N +: N] = 32'h0000_0000;
        req_cin[3]      = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
`ifndef ADD_ARB_PRIO0_EN
        // Round-robin under full contention: one result per cycle, in order 0,1,2,3,...
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_valid", 64'(rsp_valid), 64'd1);
            check("rr_id",    64'(rsp_id),    64'(k % R));
            if (k % R == 3) begin
                check("rr3_sum",  64'(rsp_sum),  64'd0);
                check("rr3_cout", 64'(rsp_cout), 64'd1);
                check("rr3_of",   64'(rsp_of),   64'd0);
            end
        end

        // Backpressure: the result holds and no requester is accepted
        saved_sum = rsp_sum;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_sum",   64'(rsp_sum),   64'(saved_sum));
            check("bp_id",    64'(rsp_id),    64'd3);
            check("bp_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_next_id", 64'(rsp_id), 64'd0);

        // Consume and accept in the same edge
        req_valid = 4'b0010;
        step();
        check("swap_valid", 64'(rsp_valid), 64'd1);
        check("swap_id",    64'(rsp_id),    64'd1);

        // Reset while FULL, then the pointer restarts at 0
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        req_valid = '1;
        step();
        check("post_rst_id", 64'(rsp_id), 64'd0);
`else
        // Requester 0 always valid: it wins every cycle
        for (int k = 0; k < 6; k++) begin
            step();
            check("prio_id", 64'(rsp_id), 64'd0);
        end
`endif

        // Randomized traffic checked against the model
        req_valid = '0;
        last_xfer = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/add_share_arbiter.md
# add_share_arbiter

Round-robin arbiter and sequencer that shares one `carry_select_adder` instance (N-bit, 8-bit blocks) among R requesters. Each requester presents operands over a valid/ready handshake. The arbiter selects one requester per cycle, drives the shared adder, and captures sum, carry-out and overflow into a one-deep output register. That register carries a requester ID tag and has its own valid/ready backpressure. The block sits between the operand-producing units and the single adder datapath.

## Interface
- `N`, default 32: operand width; must be a multiple of 8 (adder block size).
- `R`, default 4: number of requesters, 2..8; `IDW = $clog2(R)`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active low.
- `req_valid`  in  R  per-requester operand valid.
- `req_ready`  out  R  per-requester accept; at most one bit high per cycle.
- `req_a`  in  R*N  operand A, requester i at `[i*N +: N]`.
- `req_b`  in  R*N  operand B, same packing.
- `req_cin`  in  R  carry-in per requester.
- `rsp_valid`  out  1  result register holds a result.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `rsp_sum`  out  N  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `rsp_of`  out  1  registered signed overflow.

## Operation
- Output stage FSM has two states:
  - EMPTY (`rsp_valid=0`).
  - FULL (`rsp_valid=1`).
- `can_accept = !rsp_valid | rsp_ready`.
- Arbitration is combinational each cycle over `req_valid`.
  - Search starts at round-robin pointer `ptr`, ascending with wrap modulo R.
  - The first valid requester is the grantee `g`.
- `req_ready[g] = can_accept`. All other `req_ready` bits are 0. With no valid request, all bits are 0.
- A transfer happens on the cycle where `req_valid[g] & req_ready[g]`. At that edge:
  - Operands and `req_cin[g]` of `g` are muxed into the shared adder.
  - Adder outputs are stored: `rsp_sum<=S`, `rsp_cout<=Cout`, `rsp_of<=OF`, `rsp_id<=g`, `rsp_valid<=1`.
  - `ptr <= (g+1) mod R`.
- Result consumed (`rsp_valid & rsp_ready`) with no new transfer: `rsp_valid<=0`. Data fields hold their last value.
- Consume and new transfer in the same cycle: the new result replaces the old. There is no bubble, so throughput is 1 result per cycle.
- FULL and `!rsp_ready`:
  - All `req_ready=0`.
  - Result fields and `ptr` hold.
  - Requesters must hold `req_valid` and operands stable (AXI-style). The arbiter does not latch operands before grant.
- `ptr` does not move on cycles without a transfer.
- Overflow definition, per the adder: set when A and B MSBs are equal and sum MSB differs. Carry-in does not enter the rule except through S.
- Reset mid-operation: any in-flight result is discarded, and no `rsp_valid` pulse follows reset.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_of=0`.
  - `ptr=0`, so `req_ready` is low until a request arrives.
- Latency: a transfer at edge k gives `rsp_valid=1` with the result from cycle k+1.
- `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
- `req_ready` does not depend on operand data.
- Adder path is combinational within the cycle (operand mux → carry-select → result register). One-cycle timing for N=32 is required.
- Fairness: under continuous contention every valid requester is granted within R transfers.

## Configuration
- `ADD_ARB_PRIO0_EN`
  - Defined: requester 0 is granted whenever `req_valid[0]=1`, regardless of `ptr`. `ptr` is not updated on a requester-0 transfer. Requesters 1..R-1 round-robin among themselves using `ptr`, and `ptr` skips index 0.
  - Undefined: pure round-robin over all R requesters as described above.

## Test plan
- Reset then idle:
  - Hold `rst_n=0` 3 cycles → all outputs 0, `req_ready=0`.
  - Release with no requests → `rsp_valid` stays 0.
- Single add:
  - Requester 2 issues A=0x7FFFFFFF, B=0x00000001, cin=0 with `rsp_ready=1`.
  - → Next cycle: `rsp_id=2`, sum=0x80000000, cout=0, of=1.
- Round-robin: all 4 requesters valid continuously with `rsp_ready=1`.
  - → Grant order is 0,1,2,3,0,…, one result per cycle.
  - Requester 3 with A=0xFFFFFFFF, B=0, cin=1 → sum=0, cout=1, of=0.
- Backpressure:
  - Hold `rsp_ready=0` for 5 cycles after a result → `rsp_valid` stays 1 with the result fields stable, all `req_ready=0`, and `ptr` unchanged.
  - Raising `rsp_ready` → the next grant follows the pointer.
- Simultaneous consume and accept:
  - FULL with `rsp_ready=1` and requester 1 valid → new result replaces the old in the same edge, with `rsp_valid` continuously 1.
- Reset mid-stream:
  - Assert `rst_n=0` while FULL → next cycle `rsp_valid=0` and `ptr=0`.
  - With `ADD_ARB_PRIO0_EN`: requester 0 valid every cycle → only requester 0 is granted and `ptr` stays constant.
